// File: rtl/imm_gen_pipe.sv
//-----------------------------------------------------------------------------
// imm_gen_pipe
//
// Decode-stage immediate generator for the RV32I/RV64I formats I, S, B, U, J
// and the CSR zimm field. The immediate is built combinationally from the
// incoming instruction. It is then stored, along with a sideband tag and an
// illegal-format flag, in a 2-entry skid buffer. The buffer has a valid/ready
// handshake on both sides. in_ready depends only on registered state, so no
// combinational path runs from out_ready to in_ready.
//
// Ports:
//   clk         - single clock, rising-edge
//   reset       - synchronous, active-high; clears all state and storage
//   flush       - synchronous; discards buffered entries and drops any push
//   in_valid    - upstream presents an instruction
//   in_ready    - buffer has a free slot (registered state only)
//   in_instr    - raw 32-bit instruction word
//   in_sel      - format: 0 I, 1 S, 2 B, 3 U, 4 J, 5 zimm, 6/7 illegal
//   in_tag      - sideband tag, carried unchanged
//   out_valid   - head entry valid
//   out_ready   - downstream consumes the head entry this cycle
//   out_imm     - XLEN-wide immediate of the head entry
//   out_tag     - tag of the head entry
//   out_illegal - head entry was presented with in_sel 6 or 7
//-----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [2:0] SEL_I = 3'd0;
    localparam logic [2:0] SEL_S = 3'd1;
    localparam logic [2:0] SEL_B = 3'd2;
    localparam logic [2:0] SEL_U = 3'd3;
    localparam logic [2:0] SEL_J = 3'd4;
    localparam logic [2:0] SEL_Z = 3'd5;

    // ------------------------------------------------------------------
    // Immediate decode. The value is always built at 64 bits and then
    // truncated to XLEN. This avoids zero-width replications when XLEN=32.
    // ------------------------------------------------------------------
    logic [63:0]     imm_wide;
    logic            illegal_new;
    logic [XLEN-1:0] imm_new;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        imm_wide    = '0;
        illegal_new = 1'b0;
        case (in_sel)
            SEL_I: imm_wide = {{52{in_instr[31]}}, in_instr[31:20]};
            SEL_S: imm_wide = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            SEL_B: imm_wide = {{51{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
            SEL_U: imm_wide = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
            SEL_J: imm_wide = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
            SEL_Z: imm_wide = {59'b0, in_instr[19:15]};
            default: illegal_new = 1'b1;   // sel 6/7: imm stays 0
        endcase
    end

    assign imm_new = imm_wide[XLEN-1:0];

    // The opcode bits never feed an immediate. The upper half of imm_wide is
    // dropped when XLEN=32.
    logic unused_bits;
    assign unused_bits = ^{in_instr[6:0], imm_wide};

    // ------------------------------------------------------------------
    // 2-entry skid buffer
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  imm_q   [2];
    logic [TAG_W-1:0] tag_q   [2];
    logic             ill_q   [2];
    logic             head;
    logic [1:0]       count;

    logic push;
    logic pop;
    logic wr_idx;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // A push only happens when count is 0 or 1. The free slot is therefore
    // head+count mod 2. This also covers push+pop at count=1, where the new
    // entry lands behind the current head.
    assign wr_idx    = head ^ count[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the storage is cleared on reset as well as the pointers, so out_* read 0 after reset.
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                tag_q[i] <= '0;
                ill_q[i] <= 1'b0;
            end
            head  <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            // Slot contents may stay stale. They are hidden by the output gating.
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
            if (push) begin
                imm_q[wr_idx] <= imm_new;
                tag_q[wr_idx] <= in_tag;
                ill_q[wr_idx] <= illegal_new;
            end
            case ({push, pop})
                2'b10: count <= count + 2'd1;
                2'b01: begin
                    count <= count - 2'd1;
                    head  <= ~head;
                end
                2'b11: head <= ~head;
                default: ;
            endcase
        end
    end

    // Gate with out_valid so stale slots left by flush are never seen.
    assign out_imm     = out_valid ? imm_q[head] : '0;
    assign out_tag     = out_valid ? tag_q[head] : '0;
    assign out_illegal = out_valid && ill_q[head];

endmodule

// File: tb/tb_imm_gen_pipe.sv
//-----------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Directed bench for imm_gen_pipe. Two instances, one with XLEN=32 and one
// with XLEN=64, share the same stimulus. Both 32- and 64-bit immediates are
// therefore compared against hand-computed values. Inputs change 1 ns after
// the rising edge, and outputs are sampled at the same point.
//-----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_sel;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready_a,  in_ready_b;
    logic        out_valid_a, out_valid_b;
    logic [31:0] out_imm_a;
    logic [63:0] out_imm_b;
    logic [7:0]  out_tag_a,   out_tag_b;
    logic        out_illegal_a, out_illegal_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready_a),
        .in_instr   (in_instr),
        .in_sel     (in_sel),
        .in_tag     (in_tag),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready),
        .out_imm    (out_imm_a),
        .out_tag    (out_tag_a),
        .out_illegal(out_illegal_a)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready_b),
        .in_instr   (in_instr),
        .in_sel     (in_sel),
        .in_tag     (in_tag),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready),
        .out_imm    (out_imm_b),
        .out_tag    (out_tag_b),
        .out_illegal(out_illegal_b)
    );

    task automatic check(input string name, input logic [63:0] observed,
                         input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare the head entry of both instances.
    task automatic check_out(input string name, input logic valid,
                             input logic [31:0] imm32, input logic [63:0] imm64,
                             input logic [7:0] tag, input logic ill);
        check({name, ".valid32"}, 64'(out_valid_a), 64'(valid));
        check({name, ".valid64"}, 64'(out_valid_b), 64'(valid));
        check({name, ".imm32"},   64'(out_imm_a),   64'(imm32));
        check({name, ".imm64"},   out_imm_b,        imm64);
        check({name, ".tag32"},   64'(out_tag_a),   64'(tag));
        check({name, ".tag64"},   64'(out_tag_b),   64'(tag));
        check({name, ".ill32"},   64'(out_illegal_a), 64'(ill));
        check({name, ".ill64"},   64'(out_illegal_b), 64'(ill));
    endtask

    task automatic check_ready(input string name, input logic rdy);
        check({name, ".ready32"}, 64'(in_ready_a), 64'(rdy));
        check({name, ".ready64"}, 64'(in_ready_b), 64'(rdy));
    endtask

    // Present one instruction with out_ready high. The following edge
    // accepts it, and it is then the head entry.
    task automatic push_one(input string name, input logic [31:0] instr,
                            input logic [2:0] sel, input logic [7:0] tag,
                            input logic [31:0] imm32, input logic [63:0] imm64,
                            input logic ill);
        in_instr  = instr;
        in_sel    = sel;
        in_tag    = tag;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        check_out(name, 1'b1, imm32, imm64, tag, ill);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_sel    = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_out("reset", 1'b0, 32'h0, 64'h0, 8'h00, 1'b0);
        check_ready("reset", 1'b1);

        // ---- Format coverage at full rate (each step is push+pop) ----
        push_one("fmt_i",  32'hFFF00093, 3'd0, 8'h01, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
        push_one("fmt_b",  32'hFE000EE3, 3'd2, 8'h02, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
        push_one("fmt_u",  32'h123450B7, 3'd3, 8'h03, 32'h12345000, 64'h00000000_12345000, 1'b0);
        push_one("fmt_j",  32'h001000EF, 3'd4, 8'h04, 32'h00000800, 64'h00000000_00000800, 1'b0);
        push_one("fmt_z",  32'h000F8073, 3'd5, 8'h05, 32'h0000001F, 64'h00000000_0000001F, 1'b0);
        push_one("fmt_s",  32'h00112623, 3'd1, 8'h06, 32'h0000000C, 64'h00000000_0000000C, 1'b0);
        push_one("fmt_un", 32'h800000B7, 3'd3, 8'h07, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0);
        push_one("fmt_il", 32'hFFFFFFFF, 3'd7, 8'h08, 32'h00000000, 64'h00000000_00000000, 1'b1);
        push_one("fmt_i6", 32'hFFF00093, 3'd6, 8'h09, 32'h00000000, 64'h00000000_00000000, 1'b1);
        step();
        check_out("drain0", 1'b0, 32'h0, 64'h0, 8'h00, 1'b0);

        // ---- Backpressure: fill to 2, third push refused ----
        out_ready = 1'b0;
        in_instr  = 32'hFFF00093;
        in_sel    = 3'd0;
        in_valid  = 1'b1;
        in_tag    = 8'd1;
        step();
        check_ready("bp_1", 1'b1);
        check_out("bp_1", 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 8'd1, 1'b0);
        in_tag = 8'd2;
        in_instr = 32'h00112623;
        in_sel   = 3'd1;
        step();
        check_ready("bp_2", 1'b0);
        check_out("bp_2", 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 8'd1, 1'b0);
        in_tag = 8'd3;
        in_instr = 32'h123450B7;
        in_sel   = 3'd3;
        step();
        check_ready("bp_hold", 1'b0);
        check_out("bp_hold", 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 8'd1, 1'b0);
        out_ready = 1'b1;           // tag 3 is still offered
        step();
        check_ready("bp_pop1", 1'b1);
        check_out("bp_pop1", 1'b1, 32'h0000000C, 64'h0000000C, 8'd2, 1'b0);
        step();                     // tag 3 pushed, tag 2 popped
        in_valid = 1'b0;
        check_out("bp_pop2", 1'b1, 32'h12345000, 64'h12345000, 8'd3, 1'b0);
        step();
        check_out("bp_empty", 1'b0, 32'h0, 64'h0, 8'h00, 1'b0);

        // ---- Sustained push+pop at count=1 ----
        in_instr  = 32'h001000EF;
        in_sel    = 3'd4;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_tag = 8'(8'h10 + i);
            step();
            check_ready("stream", 1'b1);
            check_out("stream", 1'b1, 32'h00000800, 64'h00000800, 8'(8'h10 + i), 1'b0);
        end
        in_valid = 1'b0;
        step();
        check_out("stream_end", 1'b0, 32'h0, 64'h0, 8'h00, 1'b0);

        // ---- Flush with count=2 and a push offered ----
        out_ready = 1'b0;
        in_instr  = 32'hFFF00093;
        in_sel    = 3'd0;
        in_valid  = 1'b1;
        in_tag    = 8'h20;
        step();
        in_tag    = 8'h21;
        step();
        check_ready("fl_full", 1'b0);
        flush  = 1'b1;
        in_tag = 8'h22;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_out("flush", 1'b0, 32'h0, 64'h0, 8'h00, 1'b0);
        check_ready("flush", 1'b1);
        out_ready = 1'b1;
        step();
        check_out("flush_gone", 1'b0, 32'h0, 64'h0, 8'h00, 1'b0);
        push_one("post_flush", 32'h00112623, 3'd1, 8'h23, 32'h0000000C, 64'h0000000C, 1'b0);
        step();

        // ---- Reset mid-stream ----
        out_ready = 1'b0;
        in_instr  = 32'hFFF00093;
        in_sel    = 3'd0;
        in_tag    = 8'h30;
        in_valid  = 1'b1;
        step();
        check_out("pre_rst", 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 8'h30, 1'b0);
        reset = 1'b1;
        step();
        check_out("mid_rst", 1'b0, 32'h0, 64'h0, 8'h00, 1'b0);
        check_ready("mid_rst", 1'b1);
        step();                     // push offered during reset is not recorded
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        check_out("rst_nopush", 1'b0, 32'h0, 64'h0, 8'h00, 1'b0);

        // ---- Reset takes priority over flush ----
        push_one("pre_rf", 32'h123450B7, 3'd3, 8'h40, 32'h12345000, 64'h12345000, 1'b0);
        reset = 1'b1;
        flush = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        check_out("rst_flush", 1'b0, 32'h0, 64'h0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
